pipe_hazard_ctrl: RTL

Hazard and stall sequencer for the 5-stage MIPS pipeline. It sits beside the ID-stage instruction decoder and drives the pipeline-register enables and flushes, plus the EX-stage forwarding selects. It resolves load-use interlocks, ID-stage redirects (j/jal/jr/taken beq) and multi-cycle data-memory waits. A watchdog flags a data memory that never answers.

---
 rtl/pipe_hazard_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage MIPS pipeline: load-use interlock,
// ID redirect flush, data-memory wait freeze with watchdog, and EX forwarding selects.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_redirect,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_we,
    input  logic             ex_load,
    input  logic [4:0]       mem_rd,
    input  logic             mem_we,
    input  logic [4:0]       wb_rd,
    input  logic             wb_we,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {RUN, MEMWAIT} state_e;

    state_e            state_q, state_d;
    logic [15:0]       wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic timeout;
    logic freeze;
    logic load_use;

    assign timeout  = (state_q == MEMWAIT) && (wait_cnt_q == 16'(TIMEOUT - 1));
    assign freeze   = ((state_q == RUN) && mem_access && !dmem_ready) ||
                      ((state_q == MEMWAIT) && !dmem_ready && !timeout);
    assign load_use = ex_load && ex_we && (ex_rd != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == src))
            return 2'b10;
        else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Pipeline controls; reset parks every stage with a bubble.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        fwd_a_sel   = fwd_sel(ex_rs);
        fwd_b_sel   = fwd_sel(ex_rt);
        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
            fwd_a_sel   = 2'b00;
            fwd_b_sel   = 2'b00;
        end else if (freeze) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (id_redirect) begin
            ifid_flush = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        stall_d    = stall_q;
        case (state_q)
            RUN: begin
                if (mem_access && !dmem_ready) begin
                    state_d    = MEMWAIT;
                    wait_cnt_d = 16'd0;
                end
            end
            MEMWAIT: begin
                if (dmem_ready) begin
                    state_d = RUN;
                end else if (timeout) begin
                    state_d   = RUN;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            default: state_d = RUN;
        endcase
        if (!pc_en && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= 16'd0;
            mem_err_q  <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
            stall_q    <= stall_d;
        end
    end

    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_q;

endmodule
